// File: rtl/oh_arbiter_if.sv
// rtl/oh_arbiter_if.sv - requester, operand-handler and response signals of oh_arbiter
//
// Ports (grouped as interface members):
//   r0_*/r1_*  : requester valid/ready handshake plus rb/i/s operands
//   oh_*       : operands presented to the shared operand handler, oh_n its result
//   rsp_*      : response valid/ready handshake with owner id, result and error flag
// Modports: master = requesters/handler/consumer side, slave = arbiter side.
interface oh_arbiter_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [31:0] r0_rb;
  logic [20:0] r0_i;
  logic [2:0]  r0_s;

  logic        r1_valid;
  logic        r1_ready;
  logic [31:0] r1_rb;
  logic [20:0] r1_i;
  logic [2:0]  r1_s;

  logic [31:0] oh_rb;
  logic [20:0] oh_i;
  logic [2:0]  oh_s;
  logic [31:0] oh_n;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_n;
  logic        rsp_err;

  modport master (
    output r0_valid, r0_rb, r0_i, r0_s,
    output r1_valid, r1_rb, r1_i, r1_s,
    output oh_n, rsp_ready,
    input  r0_ready, r1_ready,
    input  oh_rb, oh_i, oh_s,
    input  rsp_valid, rsp_id, rsp_n, rsp_err
  );

  modport slave (
    input  r0_valid, r0_rb, r0_i, r0_s,
    input  r1_valid, r1_rb, r1_i, r1_s,
    input  oh_n, rsp_ready,
    output r0_ready, r1_ready,
    output oh_rb, oh_i, oh_s,
    output rsp_valid, rsp_id, rsp_n, rsp_err
  );
endinterface

// File: rtl/oh_arbiter.sv
// rtl/oh_arbiter.sv - two-requester round-robin arbiter in front of a shared operand handler
//
// Ports:
//   clk   : rising-edge clock for all state
//   reset : synchronous active-high reset
//   bus   : oh_arbiter_if.slave (requesters, operand handler, response channel)
// Parameter FIRST_GRANT selects the winner of the first contended arbitration.
module oh_arbiter #(
  parameter int FIRST_GRANT = 0
) (
  input  logic          clk,
  input  logic          reset,
  oh_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rb_q, rb_d;
  logic [20:0] i_q, i_d;
  logic [2:0]  s_q, s_d;
  logic        gnt_id_q, gnt_id_d;
  logic        last_q, last_d;
  logic [31:0] rsp_n_q, rsp_n_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic slot_free;
  logic accept;
  logic gnt;

  // A new operation can enter when nothing is held, or when the held
  // response is being taken this very cycle.
  assign slot_free = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign accept    = slot_free && (bus.r0_valid || bus.r1_valid) && !reset;

  // Under contention the requester not granted last time wins.
  assign gnt = (bus.r0_valid && bus.r1_valid) ? ~last_q : bus.r1_valid;

  always_comb begin
    state_d   = state_q;
    rb_d      = rb_q;
    i_d       = i_q;
    s_d       = s_q;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    rsp_n_d   = rsp_n_q;
    rsp_id_d  = rsp_id_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      IDLE: ;
      EXEC: begin
        // oh_n is only looked at here, while the operand registers are stable.
        rsp_n_d   = bus.oh_n;
        rsp_id_d  = gnt_id_q;
        rsp_err_d = (s_q == 3'b111);
        state_d   = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept overrides the IDLE hold and the RESP->IDLE return.
    if (accept) begin
      rb_d     = gnt ? bus.r1_rb : bus.r0_rb;
      i_d      = gnt ? bus.r1_i  : bus.r0_i;
      s_d      = gnt ? bus.r1_s  : bus.r0_s;
      gnt_id_d = gnt;
      last_d   = gnt;
      state_d  = EXEC;
    end

    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rb_q        <= '0;
      i_q         <= '0;
      s_q         <= '0;
      gnt_id_q    <= 1'b0;
      last_q      <= (FIRST_GRANT == 0) ? 1'b1 : 1'b0;
      rsp_n_q     <= '0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rb_q        <= rb_d;
      i_q         <= i_d;
      s_q         <= s_d;
      gnt_id_q    <= gnt_id_d;
      last_q      <= last_d;
      rsp_n_q     <= rsp_n_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.r0_ready  = accept && !gnt;
  assign bus.r1_ready  = accept && gnt;
  assign bus.oh_rb     = rb_q;
  assign bus.oh_i      = i_q;
  assign bus.oh_s      = s_q;
  // Reset asserted in RESP suppresses the response in that same cycle.
  assign bus.rsp_valid = rsp_valid_q && !reset;
  assign bus.rsp_n     = rsp_n_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/oh_arbiter.md
OH_ARBITER -- requirements
Module: oh_arbiter

Interface
REQ-001 SHALL have parameter FIRST_GRANT, default 0, meaning the requester that wins the first contended arbitration after reset (0 or 1).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port r0_valid  input  1  requester 0 presents an operation.
REQ-006 SHALL have port r0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 SHALL have port r0_rb  input  32  requester 0 register operand.
REQ-008 SHALL have port r0_i  input  21  requester 0 immediate field.
REQ-009 SHALL have port r0_s  input  3  requester 0 operand-handler select.
REQ-010 SHALL have ports r1_valid, r1_ready, r1_rb, r1_i and r1_s, identical to the r0_* ports, for requester 1.
REQ-011 SHALL have port oh_rb  output  32  register operand driven to the shared operand handler.
REQ-012 SHALL have port oh_i  output  21  immediate driven to the shared operand handler.
REQ-013 SHALL have port oh_s  output  3  select driven to the shared operand handler.
REQ-014 SHALL have port oh_n  input  32  combinational result returned by the operand handler.
REQ-015 SHALL have port rsp_valid  output  1  response holds a result.
REQ-016 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-017 SHALL have port rsp_id  output  1  requester that owns the response.
REQ-018 SHALL have port rsp_n  output  32  captured operand-handler result.
REQ-019 SHALL have port rsp_err  output  1  response came from reserved select 3'b111.

Function
REQ-020 SHALL implement an FSM with three states: IDLE, EXEC and RESP.
REQ-021 SHALL define "accept" as: state is IDLE, or state is RESP with rsp_ready=1; and at least one rX_valid is high.
REQ-022 On accept, SHALL latch the granted rb/i/s into the operand registers and the grant id, then enter EXEC.
REQ-023 SHALL drive oh_rb, oh_i and oh_s only from the operand registers, never combinationally from the requester ports.
REQ-024 In EXEC, SHALL capture oh_n into rsp_n, set rsp_id to the grant id, set rsp_err=(oh_s==3'b111), and enter RESP.
REQ-025 SHALL assert rsp_valid exactly while in RESP, holding rsp_n, rsp_id and rsp_err stable until the handshake (rsp_valid & rsp_ready).
REQ-026 On the RESP handshake with no accept, SHALL return to IDLE.
REQ-027 On the RESP handshake with an accept in the same cycle, SHALL go directly to EXEC, sustaining one operation per 2 cycles.
REQ-028 SHALL give a latency of 2 clock edges from accept to rsp_valid=1.
REQ-029 SHALL assert rX_ready in the accept cycle for the granted requester only, with at most one rX_ready high per cycle.
REQ-030 SHALL grant the sole valid requester when only one is valid.
REQ-031 When both requesters are valid, SHALL grant the one not granted most recently (round-robin).
REQ-032 SHALL update the last-grant pointer on every accept.
REQ-033 SHALL ignore rX_valid in EXEC, and in RESP while rsp_ready=0 (rX_ready=0 in both cases).
REQ-034 SHALL treat requester inputs as don't-care while rX_valid=0.
REQ-035 SHALL not depend on oh_n in any state other than EXEC.

Reset
REQ-036 When reset=1 at a clock edge, SHALL set state=IDLE, the operand registers to 0, rsp_n=0, rsp_id=0 and rsp_err=0.
REQ-037 When reset=1 at a clock edge, SHALL set the last-grant pointer to ~FIRST_GRANT.
REQ-038 While reset=1, SHALL hold rsp_valid=0, r0_ready=0 and r1_ready=0.
REQ-039 Reset asserted in EXEC or RESP SHALL discard the in-flight operation, produce no response, and accept nothing in that cycle.

Verification
REQ-040 Single request: r0 valid, rb=32'hDEADBEEF, s=000, rsp_ready=1 -> r0_ready for 1 cycle; 2 edges later rsp_valid=1, rsp_n=32'hDEADBEEF, rsp_id=0, rsp_err=0.
REQ-041 Contention: both requesters held valid after reset (FIRST_GRANT=0) -> grant order r0,r1,r0,r1, one accept every 2 cycles.
REQ-042 Backpressure: r1 with s=011, i=21'h000001, rsp_ready=0 for 5 cycles -> rsp_n=32'h00000800 held stable, no rX_ready; rsp_ready=1 with r0 valid -> handshake and r0 accept in the same cycle.
REQ-043 Reserved select: r0 with s=111 -> rsp_err=1 with rsp_n equal to the oh_n value sampled in EXEC; the following s=000 response -> rsp_err=0.
REQ-044 Mid-operation reset: assert reset in EXEC -> next cycle state IDLE, rsp_valid=0, oh_rb=0, no stale response afterwards.
REQ-045 Isolation: a requester whose rX_valid=0 and whose inputs toggle -> oh_rb, oh_i and oh_s remain unchanged.
